// File: rtl/portas_logicas_checker.sv
// portas_logicas_checker
// Response checker for the 3-bit logic-gate block. It accepts a vector on
// vec_valid, waits SETTLE_CYC cycles, samples s1..s8 and compares them with
// values computed from the captured operands. It counts vectors and
// mismatches, records the first failing {a,b} and flags done after NUM_VEC
// vectors.
// Optional build macro CHK_FAIL_MASK_EN adds the sticky per-gate fail_mask
// output.
module portas_logicas_checker #(
    parameter int SETTLE_CYC = 2,   // 1..15
    parameter int NUM_VEC    = 6,   // 1..255
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       a,
    input  logic [2:0]       b,
    input  logic [2:0]       s1,
    input  logic [2:0]       s2,
    input  logic [2:0]       s3,
    input  logic [2:0]       s4,
    input  logic [2:0]       s5,
    input  logic [2:0]       s6,
    input  logic [2:0]       s7,
    input  logic             s8,
    input  logic             vec_valid,
    output logic             ready,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [5:0]       first_err_vec,
    output logic             err_flag,
    output logic             done
`ifdef CHK_FAIL_MASK_EN
    ,
    output logic [7:0]       fail_mask
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t           state;
    state_t           state_next;
    logic [3:0]       settle_cnt;
    logic [2:0]       a_cap;
    logic [2:0]       b_cap;
    logic [7:0]       gate_bad;    // bit k-1 set when sk differs from expected
    logic             any_bad;
    logic [CNT_W-1:0] vec_next;
    logic [CNT_W-1:0] err_next;
    logic             last_vec;

    // Expected gate outputs from the captured operands against the live s1..s8.
    always_comb begin
        gate_bad[0] = (s1 != (a_cap & b_cap));
        gate_bad[1] = (s2 != (a_cap | b_cap));
        gate_bad[2] = (s3 != ~(a_cap & b_cap));
        gate_bad[3] = (s4 != ~(a_cap | b_cap));
        gate_bad[4] = (s5 != (a_cap ^ b_cap));
        gate_bad[5] = (s6 != ~(a_cap ^ b_cap));
        gate_bad[6] = (s7 != ~a_cap);
        gate_bad[7] = (s8 != (a_cap == b_cap));
        any_bad     = |gate_bad;
    end

    // Saturating counter increments and the end-of-run test on the new count.
    always_comb begin
        vec_next = (vec_count == CNT_MAX) ? vec_count : vec_count + CNT_ONE;
        err_next = (err_count == CNT_MAX) ? err_count : err_count + CNT_ONE;
        // Compare at full width so a narrow counter can never alias NUM_VEC.
        last_vec = (int'(vec_next) == NUM_VEC);
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: default assignment first keeps every path assigned, so no latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vec_valid) state_next = SETTLE;
            SETTLE:  if (settle_cnt == 4'd0) state_next = COMPARE;
            COMPARE: state_next = last_vec ? DONE : IDLE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the state alone.
    always_comb begin
        ready = (state == IDLE);
        done  = (state == DONE);
    end

    // Operand capture and settle countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cap      <= 3'd0;
            b_cap      <= 3'd0;
            settle_cnt <= 4'd0;
        end else begin
            if (state == IDLE && vec_valid) begin
                a_cap      <= a;
                b_cap      <= b;
                settle_cnt <= SETTLE_LOAD;
            end else if (state == SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
        end
    end

    // Result bookkeeping, updated only in the single COMPARE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_count     <= '0;
            err_count     <= '0;
            first_err_vec <= 6'd0;
            err_flag      <= 1'b0;
        end else if (state == COMPARE) begin
            vec_count <= vec_next;
            if (any_bad) begin
                err_count <= err_next;
                err_flag  <= 1'b1;
                if (!err_flag) begin
                    first_err_vec <= {a_cap, b_cap};
                end
            end
        end
    end

`ifdef CHK_FAIL_MASK_EN
    // Sticky record of which gates have ever mismatched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_mask <= 8'd0;
        end else if (state == COMPARE) begin
            fail_mask <= fail_mask | gate_bad;
        end
    end
`else
`endif

endmodule
